// File: rtl/cmd_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_scheduler_pkg
//  Purpose  : Shared definitions for the command scheduler and the physical
//             layer blocks: frame widths, default timing parameters, FSM
//             state encoding, grantee identifiers and a counter-width helper.
//  Revision : 1.0  initial release
// ============================================================================
package cmd_scheduler_pkg;

    localparam int CMD_W          = 40;
    localparam int RESP_W         = 15;
    localparam int DEF_MAX_RETRY  = 2;
    localparam int DEF_GAP_CYCLES = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_ACK       = 3'd3,
        ST_GAP       = 3'd4
    } sched_state_e;

    typedef enum logic {
        GNT_SW   = 1'b0,
        GNT_AUTO = 1'b1
    } grantee_e;

    // Bits needed to hold values 0..n; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_arbiter_fp.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_arbiter_fp
//  Purpose  : Fixed-priority requester pick (auto-stop beats software) and a
//             registered latch holding the grantee of the running transaction.
//  Ports    : sd_clock, reset        clock / async active-high reset
//             req_sw, req_auto       pending requests
//             grant_en               load the current pick into the latch
//             any_req                at least one request pending (comb.)
//             pick                   requester that would win now (comb.)
//             grantee_q              latched grantee
//  Revision : 1.0  initial release
// ============================================================================
module cmd_arbiter_fp
    import cmd_scheduler_pkg::*;
(
    input  logic     sd_clock,
    input  logic     reset,
    input  logic     req_sw,
    input  logic     req_auto,
    input  logic     grant_en,
    output logic     any_req,
    output grantee_e pick,
    output grantee_e grantee_q
);

    grantee_e grantee_d;

    always_comb begin
        any_req   = req_sw | req_auto;
        pick      = req_auto ? GNT_AUTO : GNT_SW;
        grantee_d = grant_en ? pick : grantee_q;
    end

    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            grantee_q <= GNT_SW;
        end else begin
            grantee_q <= grantee_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cmd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_scheduler
//  Purpose  : Arbitrates two command requesters onto one physical-layer
//             command port, handles the strobe/ack handshakes, response
//             capture, timeout retries and the mandatory inter-command gap.
//  Ports    : sd_clock, reset              clock / async active-high reset
//             req_*, cmd_*, no_resp_*      requester side (sw, auto)
//             done_*, resp_out, timeout_err completion reporting
//             phy_strobe/ack/idle/no_response/cmd   to physical layer
//             phy_ack_out/strobe_out/timeout/response from physical layer
//  Revision : 1.0  initial release
// ============================================================================
module cmd_scheduler
    import cmd_scheduler_pkg::*;
#(
    parameter int MAX_RETRY  = DEF_MAX_RETRY,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic              sd_clock,
    input  logic              reset,
    input  logic              req_sw,
    input  logic              req_auto,
    input  logic [CMD_W-1:0]  cmd_sw,
    input  logic [CMD_W-1:0]  cmd_auto,
    input  logic              no_resp_sw,
    input  logic              no_resp_auto,
    output logic              done_sw,
    output logic              done_auto,
    output logic [RESP_W-1:0] resp_out,
    output logic              timeout_err,
    output logic              phy_strobe,
    output logic              phy_ack,
    output logic              phy_idle,
    output logic              phy_no_response,
    output logic [CMD_W-1:0]  phy_cmd,
    input  logic              phy_ack_out,
    input  logic              phy_strobe_out,
    input  logic              phy_timeout,
    input  logic [RESP_W-1:0] phy_response
);

    localparam int RETRY_W = cnt_width(MAX_RETRY);
    localparam int GAP_W   = cnt_width(GAP_CYCLES);

    sched_state_e        state_q,      state_d;
    logic [CMD_W-1:0]    cmd_q,        cmd_d;
    logic                no_resp_q,    no_resp_d;
    logic [RETRY_W-1:0]  retry_cnt_q,  retry_cnt_d;
    logic                retry_flag_q, retry_flag_d;
    logic [GAP_W-1:0]    gap_cnt_q,    gap_cnt_d;
    logic [RESP_W-1:0]   resp_q,       resp_d;
    logic                terr_q,       terr_d;
    logic                done_sw_q,    done_sw_d;
    logic                done_auto_q,  done_auto_d;

    logic                any_req;
    grantee_e            pick;
    grantee_e            grantee_q;
    logic                grant_en;
    logic                done_pulse;

    cmd_arbiter_fp u_arbiter (
        .sd_clock  (sd_clock),
        .reset     (reset),
        .req_sw    (req_sw),
        .req_auto  (req_auto),
        .grant_en  (grant_en),
        .any_req   (any_req),
        .pick      (pick),
        .grantee_q (grantee_q)
    );

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        no_resp_d    = no_resp_q;
        retry_cnt_d  = retry_cnt_q;
        retry_flag_d = retry_flag_q;
        gap_cnt_d    = gap_cnt_q;
        resp_d       = resp_q;
        terr_d       = terr_q;
        grant_en     = 1'b0;
        done_pulse   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_en     = 1'b1;
                    cmd_d        = (pick == GNT_AUTO) ? cmd_auto : cmd_sw;
                    no_resp_d    = (pick == GNT_AUTO) ? no_resp_auto : no_resp_sw;
                    retry_cnt_d  = '0;
                    retry_flag_d = 1'b0;
                    state_d      = ST_SEND;
                end
            end

            ST_SEND: begin
                if (phy_ack_out) begin
                    if (no_resp_q) begin
                        // Fire-and-forget command: complete as soon as the
                        // physical layer accepts it; resp_out is left alone.
                        done_pulse = 1'b1;
                        terr_d     = 1'b0;
                        gap_cnt_d  = '0;
                        state_d    = ST_GAP;
                    end else begin
                        state_d    = ST_WAIT_RESP;
                    end
                end
            end

            ST_WAIT_RESP: begin
                // A response arriving together with a timeout wins.
                if (phy_strobe_out) begin
                    resp_d       = phy_response;
                    retry_flag_d = 1'b0;
                    state_d      = ST_ACK;
                end else if (phy_timeout) begin
                    retry_flag_d = 1'b1;
                    state_d      = ST_ACK;
                end
            end

            ST_ACK: begin
                if (!phy_strobe_out && !phy_timeout) begin
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                    if (retry_flag_q) begin
                        if (retry_cnt_q < RETRY_W'(MAX_RETRY)) begin
                            // Keep retry_flag set so GAP resends the latched
                            // command instead of returning to arbitration.
                            retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                        end else begin
                            retry_flag_d = 1'b0;
                            done_pulse   = 1'b1;
                            terr_d       = 1'b1;
                        end
                    end else begin
                        done_pulse = 1'b1;
                        terr_d     = 1'b0;
                    end
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    gap_cnt_d = '0;
                    if (retry_flag_q) begin
                        retry_flag_d = 1'b0;
                        state_d      = ST_SEND;
                    end else begin
                        state_d      = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_sw_d   = done_pulse && (grantee_q == GNT_SW);
        done_auto_d = done_pulse && (grantee_q == GNT_AUTO);
    end

    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            no_resp_q    <= 1'b0;
            retry_cnt_q  <= '0;
            retry_flag_q <= 1'b0;
            gap_cnt_q    <= '0;
            resp_q       <= '0;
            terr_q       <= 1'b0;
            done_sw_q    <= 1'b0;
            done_auto_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            no_resp_q    <= no_resp_d;
            retry_cnt_q  <= retry_cnt_d;
            retry_flag_q <= retry_flag_d;
            gap_cnt_q    <= gap_cnt_d;
            resp_q       <= resp_d;
            terr_q       <= terr_d;
            done_sw_q    <= done_sw_d;
            done_auto_q  <= done_auto_d;
        end
    end

    assign phy_strobe      = (state_q == ST_SEND);
    assign phy_ack         = (state_q == ST_ACK);
    assign phy_idle        = (state_q == ST_IDLE) || (state_q == ST_GAP);
    assign phy_cmd         = cmd_q;
    assign phy_no_response = no_resp_q;
    assign done_sw         = done_sw_q;
    assign done_auto       = done_auto_q;
    assign resp_out        = resp_q;
    assign timeout_err     = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_cmd_scheduler
//  Purpose  : Self-checking bench for cmd_scheduler with a reactive
//             physical-layer model and a completion scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cmd_scheduler;
    import cmd_scheduler_pkg::*;

    localparam int MAX_RETRY  = 2;
    localparam int GAP_CYCLES = 8;

    logic              sd_clock = 1'b0;
    logic              reset;
    logic              req_sw, req_auto;
    logic [CMD_W-1:0]  cmd_sw, cmd_auto;
    logic              no_resp_sw, no_resp_auto;
    logic              done_sw, done_auto;
    logic [RESP_W-1:0] resp_out;
    logic              timeout_err;
    logic              phy_strobe, phy_ack, phy_idle, phy_no_response;
    logic [CMD_W-1:0]  phy_cmd;
    logic              phy_ack_out    = 1'b0;
    logic              phy_strobe_out = 1'b0;
    logic              phy_timeout    = 1'b0;
    logic [RESP_W-1:0] phy_response   = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 sd_clock = ~sd_clock;
    always @(posedge sd_clock) cyc = cyc + 1;

    cmd_scheduler #(.MAX_RETRY(MAX_RETRY), .GAP_CYCLES(GAP_CYCLES)) dut (
        .sd_clock        (sd_clock),
        .reset           (reset),
        .req_sw          (req_sw),
        .req_auto        (req_auto),
        .cmd_sw          (cmd_sw),
        .cmd_auto        (cmd_auto),
        .no_resp_sw      (no_resp_sw),
        .no_resp_auto    (no_resp_auto),
        .done_sw         (done_sw),
        .done_auto       (done_auto),
        .resp_out        (resp_out),
        .timeout_err     (timeout_err),
        .phy_strobe      (phy_strobe),
        .phy_ack         (phy_ack),
        .phy_idle        (phy_idle),
        .phy_no_response (phy_no_response),
        .phy_cmd         (phy_cmd),
        .phy_ack_out     (phy_ack_out),
        .phy_strobe_out  (phy_strobe_out),
        .phy_timeout     (phy_timeout),
        .phy_response    (phy_response)
    );

    // ---------------- physical layer model ----------------
    // phy_mode: 0 = response, 1 = timeout, 2 = response and timeout together
    int                phy_mode   = 0;
    int                resp_delay = 2;
    logic [RESP_W-1:0] phy_val    = '0;
    int                ps         = 0;
    int                pcnt       = 0;
    int                last_ack_cyc = 0;

    always @(negedge sd_clock) begin
        if (reset) begin
            ps = 0; phy_ack_out = 1'b0; phy_strobe_out = 1'b0; phy_timeout = 1'b0;
        end else begin
            case (ps)
                0: if (phy_strobe) begin
                    phy_ack_out = 1'b1; last_ack_cyc = cyc; ps = 1;
                end
                1: begin
                    phy_ack_out = 1'b0;
                    if (phy_idle) ps = 0;
                    else begin pcnt = resp_delay; ps = 2; end
                end
                2: if (pcnt > 0) pcnt = pcnt - 1;
                   else begin
                       phy_response   = phy_val;
                       phy_strobe_out = (phy_mode != 1);
                       phy_timeout    = (phy_mode != 0);
                       ps = 3;
                   end
                3: if (phy_ack) begin
                    phy_strobe_out = 1'b0; phy_timeout = 1'b0; ps = 0;
                end
                default: ps = 0;
            endcase
        end
    end

    // ---------------- observation / scoreboard ----------------
    typedef struct { int cyc; logic [CMD_W-1:0] cmd; } strobe_t;
    typedef struct { int cyc; logic sw; logic au; logic terr; logic [RESP_W-1:0] resp; } done_t;

    strobe_t strobe_q[$];
    done_t   done_q[$];
    done_t   exp_q[$];
    logic    prev_strobe = 1'b0;
    logic    saw_wait    = 1'b0;

    always @(negedge sd_clock) begin
        if (phy_strobe && !prev_strobe) strobe_q.push_back(strobe_t'{cyc, phy_cmd});
        prev_strobe = phy_strobe;
        if (done_sw || done_auto)
            done_q.push_back(done_t'{cyc, done_sw, done_auto, timeout_err, resp_out});
        if (!reset && !phy_idle && !phy_strobe && !phy_ack) saw_wait = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge sd_clock); #1;
        total++;
        if ({phy_strobe, phy_ack, phy_idle, done_sw, done_auto, phy_no_response} !== 6'b001000) begin
            bad++; $display("FAIL reset_ctl: got %b want 001000",
                {phy_strobe, phy_ack, phy_idle, done_sw, done_auto, phy_no_response});
        end
        total++;
        if (resp_out !== 15'h0 || timeout_err !== 1'b0 || phy_cmd !== 40'h0) begin
            bad++; $display("FAIL reset_regs: resp=%h terr=%b cmd=%h want 0", resp_out, timeout_err, phy_cmd);
        end
        reset = 1'b0;
        @(negedge sd_clock); #1;
        total++;
        if (phy_idle !== 1'b1 || phy_strobe !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle: idle=%b strobe=%b want 1/0", phy_idle, phy_strobe);
        end
    endtask

    task automatic test_sw_basic();
        int c; done_t a, e;
        @(negedge sd_clock); #1;
        strobe_q.delete(); done_q.delete(); exp_q.delete();
        phy_mode = 0; resp_delay = 2; phy_val = 15'h1A5;
        cmd_sw = 40'h40_0000_0000; no_resp_sw = 1'b0; req_sw = 1'b1; c = cyc;
        exp_q.push_back(done_t'{0, 1'b1, 1'b0, 1'b0, 15'h1A5});
        for (int i = 0; i < 300 && done_q.size() < 1; i++) begin @(negedge sd_clock); #1; end
        req_sw = 1'b0;
        repeat (GAP_CYCLES + 2) @(negedge sd_clock); #1;
        total++;
        if (strobe_q.size() < 1) begin bad++; $display("FAIL sw_latency: no strobe, want cycle %0d", c + 1); end
        else if (strobe_q[0].cyc != c + 1 || strobe_q[0].cmd !== 40'h40_0000_0000) begin
            bad++; $display("FAIL sw_latency: strobe cyc=%0d cmd=%h want %0d/4000000000",
                strobe_q[0].cyc, strobe_q[0].cmd, c + 1);
        end
        total++;
        if (done_q.size() != 1) begin bad++; $display("FAIL sw_done_count: got %0d want 1", done_q.size()); end
        else begin
            a = done_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (a.sw !== e.sw || a.au !== e.au || a.terr !== e.terr || a.resp !== e.resp) begin
                bad++; $display("FAIL sw_done: sw=%b au=%b terr=%b resp=%h want %b %b %b %h",
                    a.sw, a.au, a.terr, a.resp, e.sw, e.au, e.terr, e.resp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c; done_t a, e;
        @(negedge sd_clock); #1;
        strobe_q.delete(); done_q.delete(); exp_q.delete();
        phy_mode = 0; phy_val = 15'h0F0;
        cmd_auto = 40'hA5_0000_0001; cmd_sw = 40'h5A_0000_0002;
        no_resp_auto = 1'b0; no_resp_sw = 1'b0;
        req_sw = 1'b1; req_auto = 1'b1; c = cyc;
        exp_q.push_back(done_t'{0, 1'b0, 1'b1, 1'b0, 15'h0F0});
        exp_q.push_back(done_t'{0, 1'b1, 1'b0, 1'b0, 15'h0F0});
        for (int i = 0; i < 600 && done_q.size() < 2; i++) begin
            @(negedge sd_clock); #1;
            if (done_auto) req_auto = 1'b0;
            if (done_sw)   req_sw   = 1'b0;
        end
        req_sw = 1'b0; req_auto = 1'b0;
        repeat (GAP_CYCLES + 2) @(negedge sd_clock); #1;
        total++;
        if (strobe_q.size() != 2) begin bad++; $display("FAIL prio_strobes: got %0d want 2", strobe_q.size()); end
        else begin
            total++;
            if (strobe_q[0].cmd !== 40'hA5_0000_0001 || strobe_q[0].cyc != c + 1) begin
                bad++; $display("FAIL prio_first: cmd=%h cyc=%0d want a500000001/%0d",
                    strobe_q[0].cmd, strobe_q[0].cyc, c + 1);
            end
            total++;
            if (strobe_q[1].cmd !== 40'h5A_0000_0002) begin
                bad++; $display("FAIL prio_second: cmd=%h want 5a00000002", strobe_q[1].cmd);
            end
            if (done_q.size() >= 1) begin
                total++;
                if (strobe_q[1].cyc != done_q[0].cyc + GAP_CYCLES + 1) begin
                    bad++; $display("FAIL prio_gap: strobe at %0d want %0d",
                        strobe_q[1].cyc, done_q[0].cyc + GAP_CYCLES + 1);
                end
            end
        end
        total++;
        if (done_q.size() != 2) begin bad++; $display("FAIL prio_done_count: got %0d want 2", done_q.size()); end
        else begin
            for (int k = 0; k < 2; k++) begin
                a = done_q.pop_front(); e = exp_q.pop_front();
                total++;
                if (a.sw !== e.sw || a.au !== e.au || a.terr !== e.terr || a.resp !== e.resp) begin
                    bad++; $display("FAIL prio_done%0d: sw=%b au=%b terr=%b resp=%h want %b %b %b %h",
                        k, a.sw, a.au, a.terr, a.resp, e.sw, e.au, e.terr, e.resp);
                end
            end
        end
    endtask

    task automatic test_timeout_retry();
        int nbad; done_t a, e;
        @(negedge sd_clock); #1;
        strobe_q.delete(); done_q.delete(); exp_q.delete();
        phy_mode = 1; phy_val = 15'h7777;
        cmd_sw = 40'h12_3456_789A; no_resp_sw = 1'b0; req_sw = 1'b1;
        exp_q.push_back(done_t'{0, 1'b1, 1'b0, 1'b1, 15'h0F0});
        for (int i = 0; i < 1000 && done_q.size() < 1; i++) begin @(negedge sd_clock); #1; end
        req_sw = 1'b0;
        repeat (GAP_CYCLES + 2) @(negedge sd_clock); #1;
        total++;
        if (strobe_q.size() != MAX_RETRY + 1) begin
            bad++; $display("FAIL retry_count: strobes=%0d want %0d", strobe_q.size(), MAX_RETRY + 1);
        end
        nbad = 0;
        foreach (strobe_q[k]) if (strobe_q[k].cmd !== 40'h12_3456_789A) nbad++;
        total++;
        if (nbad != 0) begin bad++; $display("FAIL retry_cmd: %0d strobes with wrong cmd, want 0", nbad); end
        total++;
        if (done_q.size() != 1) begin bad++; $display("FAIL retry_done_count: got %0d want 1", done_q.size()); end
        else begin
            a = done_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (a.sw !== e.sw || a.au !== e.au || a.terr !== e.terr || a.resp !== e.resp) begin
                bad++; $display("FAIL retry_done: sw=%b au=%b terr=%b resp=%h want %b %b %b %h",
                    a.sw, a.au, a.terr, a.resp, e.sw, e.au, e.terr, e.resp);
            end
        end
        phy_mode = 0;
    endtask

    task automatic test_no_resp();
        done_t a, e;
        @(negedge sd_clock); #1;
        strobe_q.delete(); done_q.delete(); exp_q.delete(); saw_wait = 1'b0;
        phy_mode = 0; phy_val = 15'h7FF;
        cmd_auto = 40'hFF_0000_00FF; no_resp_auto = 1'b1; req_auto = 1'b1;
        exp_q.push_back(done_t'{0, 1'b0, 1'b1, 1'b0, 15'h0F0});
        for (int i = 0; i < 300 && done_q.size() < 1; i++) begin @(negedge sd_clock); #1; end
        req_auto = 1'b0;
        repeat (GAP_CYCLES + 2) @(negedge sd_clock); #1;
        no_resp_auto = 1'b0;
        total++;
        if (saw_wait !== 1'b0) begin bad++; $display("FAIL noresp_wait: saw WAIT_RESP=%b want 0", saw_wait); end
        total++;
        if (done_q.size() != 1) begin bad++; $display("FAIL noresp_done_count: got %0d want 1", done_q.size()); end
        else begin
            a = done_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (a.cyc != last_ack_cyc + 1) begin
                bad++; $display("FAIL noresp_timing: done at %0d want %0d", a.cyc, last_ack_cyc + 1);
            end
            total++;
            if (a.sw !== e.sw || a.au !== e.au || a.terr !== e.terr || a.resp !== e.resp) begin
                bad++; $display("FAIL noresp_done: sw=%b au=%b terr=%b resp=%h want %b %b %b %h",
                    a.sw, a.au, a.terr, a.resp, e.sw, e.au, e.terr, e.resp);
            end
        end
    endtask

    task automatic test_simultaneous();
        done_t a, e;
        @(negedge sd_clock); #1;
        strobe_q.delete(); done_q.delete(); exp_q.delete();
        phy_mode = 2; phy_val = 15'h3C7;
        cmd_sw = 40'h00_DEAD_BEEF; req_sw = 1'b1;
        exp_q.push_back(done_t'{0, 1'b1, 1'b0, 1'b0, 15'h3C7});
        for (int i = 0; i < 300 && done_q.size() < 1; i++) begin @(negedge sd_clock); #1; end
        req_sw = 1'b0;
        repeat (GAP_CYCLES + 2) @(negedge sd_clock); #1;
        phy_mode = 0;
        total++;
        if (strobe_q.size() != 1) begin bad++; $display("FAIL simul_retry: strobes=%0d want 1", strobe_q.size()); end
        total++;
        if (done_q.size() != 1) begin bad++; $display("FAIL simul_done_count: got %0d want 1", done_q.size()); end
        else begin
            a = done_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (a.sw !== e.sw || a.au !== e.au || a.terr !== e.terr || a.resp !== e.resp) begin
                bad++; $display("FAIL simul_done: sw=%b au=%b terr=%b resp=%h want %b %b %b %h",
                    a.sw, a.au, a.terr, a.resp, e.sw, e.au, e.terr, e.resp);
            end
        end
    endtask

    task automatic test_reset_mid();
        int c; logic hit; done_t a, e;
        @(negedge sd_clock); #1;
        strobe_q.delete(); done_q.delete(); exp_q.delete();
        phy_mode = 0; resp_delay = 6; phy_val = 15'h155;
        cmd_sw = 40'h77_7777_7777; req_sw = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge sd_clock); #1;
            hit = !phy_idle && !phy_strobe && !phy_ack;
        end
        total++;
        if (!hit) begin bad++; $display("FAIL rmid_reach: WAIT_RESP reached=%b want 1", hit); end
        reset = 1'b1; #1;
        total++;
        if ({phy_strobe, phy_ack, phy_idle, done_sw, done_auto, phy_no_response} !== 6'b001000) begin
            bad++; $display("FAIL rmid_ctl: got %b want 001000",
                {phy_strobe, phy_ack, phy_idle, done_sw, done_auto, phy_no_response});
        end
        total++;
        if (resp_out !== 15'h0 || timeout_err !== 1'b0 || phy_cmd !== 40'h0) begin
            bad++; $display("FAIL rmid_regs: resp=%h terr=%b cmd=%h want 0", resp_out, timeout_err, phy_cmd);
        end
        repeat (2) @(negedge sd_clock); #1;
        req_sw = 1'b0; reset = 1'b0;
        repeat (20) @(negedge sd_clock); #1;
        total++;
        if (done_q.size() != 0) begin bad++; $display("FAIL rmid_no_done: got %0d pulses want 0", done_q.size()); end
        done_q.delete(); strobe_q.delete();
        resp_delay = 2; phy_val = 15'h2B3;
        cmd_auto = 40'h0C_0C0C_0C0C; req_auto = 1'b1; c = cyc;
        exp_q.push_back(done_t'{0, 1'b0, 1'b1, 1'b0, 15'h2B3});
        for (int i = 0; i < 300 && done_q.size() < 1; i++) begin @(negedge sd_clock); #1; end
        req_auto = 1'b0;
        repeat (GAP_CYCLES + 2) @(negedge sd_clock); #1;
        total++;
        if (strobe_q.size() < 1 || strobe_q[0].cyc != c + 1) begin
            bad++; $display("FAIL rmid_next_latency: strobes=%0d want first at %0d", strobe_q.size(), c + 1);
        end
        total++;
        if (done_q.size() != 1) begin bad++; $display("FAIL rmid_next_count: got %0d want 1", done_q.size()); end
        else begin
            a = done_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (a.sw !== e.sw || a.au !== e.au || a.terr !== e.terr || a.resp !== e.resp) begin
                bad++; $display("FAIL rmid_next_done: sw=%b au=%b terr=%b resp=%h want %b %b %b %h",
                    a.sw, a.au, a.terr, a.resp, e.sw, e.au, e.terr, e.resp);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req_sw = 1'b0; req_auto = 1'b0;
        cmd_sw = '0; cmd_auto = '0;
        no_resp_sw = 1'b0; no_resp_auto = 1'b0;
        test_reset();
        test_sw_basic();
        test_back_to_back();
        test_timeout_retry();
        test_no_resp();
        test_simultaneous();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
